rf_wb_arbiter: RTL and testbench

- Writeback scheduler for the single write port of the 32x32 register file (`r0` read-only; `RDaddr` = 0 means no write).
- Shares that port between two writeback requesters: A (ALU/EX result) and B (load/memory result), each through a 1-deep holding buffer, using round-robin arbitration.
- Provides decode-stage hazard flags for read addresses whose write is still queued or in flight.
- Its registered outputs drive the register file's `RDaddr`/`RD` directly.

---
 rtl/rf_wb_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback scheduler for the single register-file write port: two 1-deep buffers, round-robin grant.
// Latency: handshake at edge N -> WB_ADDR/WB_DATA valid after edge N+1; a contention loser waits one more cycle.
// Backpressure: x_READY = buffer empty or buffer granted this cycle, so one requester sustains 1 write/cycle.
// Optional contention counter enabled by defining RF_WB_STATS_EN; otherwise STAT_CONTEND is tied to 0.
module rf_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    // requester A: ALU / EX result
    input  logic              A_VALID,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    output logic              A_READY,
    // requester B: load / memory result
    input  logic              B_VALID,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              B_READY,
    // register file write port (RDaddr / RD)
    output logic [ADDR_W-1:0] WB_ADDR,
    output logic [DATA_W-1:0] WB_DATA,
    // decode-stage hazard lookup
    input  logic [ADDR_W-1:0] RSaddr,
    input  logic [ADDR_W-1:0] RTaddr,
    output logic              HAZ_RS,
    output logic              HAZ_RT,
    // contention statistics
    output logic [STAT_W-1:0] STAT_CONTEND
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              a_full_q, a_full_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;

    logic              b_full_q, b_full_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;

    // Round-robin pointer: 0 selects A, 1 selects B on a different-address tie.
    logic              rr_q, rr_d;
    // Age flag: 1 means B's entry is older than (or as old as) A's entry.
    // Only meaningful while both buffers are full.
    logic              b_first_q, b_first_d;

    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic both_full;
    logic same_addr;
    logic grant_a;
    logic grant_b;

    assign both_full = a_full_q & b_full_q;
    assign same_addr = (a_addr_q == b_addr_q);

    // Pick at most one buffer to drain, purely from registered buffer state.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (both_full) begin
            if (same_addr) begin
                // Same destination: drain strictly in arrival order so the
                // younger value is the one left in the register file.
                if (b_first_q) grant_b = 1'b1;
                else           grant_a = 1'b1;
            end else begin
                if (rr_q) grant_b = 1'b1;
                else      grant_a = 1'b1;
            end
        end else if (a_full_q) begin
            grant_a = 1'b1;
        end else if (b_full_q) begin
            grant_b = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // READY depends only on state, never on VALID, so no combinational
    // loop can form through an upstream that looks at READY.
    assign A_READY = ~a_full_q | grant_a;
    assign B_READY = ~b_full_q | grant_b;

    logic a_hs, b_hs;
    logic a_cap, b_cap;
    logic a_keep, b_keep;

    assign a_hs = A_VALID & A_READY;
    assign b_hs = B_VALID & B_READY;

    // Writes to r0 are accepted so the requester can move on, but they never
    // occupy the buffer or the write port.
    assign a_cap = a_hs & (A_ADDR != '0);
    assign b_cap = b_hs & (B_ADDR != '0);

    // An entry that stays put across this edge (full and not drained).
    assign a_keep = a_full_q & ~grant_a;
    assign b_keep = b_full_q & ~grant_b;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Buffer refill/drain, pointer and age tracking, writeback selection.
    always_comb begin
        a_full_d  = a_cap | a_keep;
        a_addr_d  = a_cap ? A_ADDR : a_addr_q;
        a_data_d  = a_cap ? A_DATA : a_data_q;

        b_full_d  = b_cap | b_keep;
        b_addr_d  = b_cap ? B_ADDR : b_addr_q;
        b_data_d  = b_cap ? B_DATA : b_data_q;

        // The pointer only advances on a both-full different-address grant;
        // it then points at whichever requester lost.
        rr_d = rr_q;
        if (both_full && !same_addr) begin
            rr_d = grant_a;
        end

        // Age: a simultaneous capture counts as B older so that A's value
        // is written last. A lone capture makes the waiting entry older.
        b_first_d = b_first_q;
        if (a_cap && b_cap) begin
            b_first_d = 1'b1;
        end else if (a_cap && b_keep) begin
            b_first_d = 1'b1;
        end else if (b_cap && a_keep) begin
            b_first_d = 1'b0;
        end

        wb_addr_d = '0;
        wb_data_d = '0;
        if (grant_a) begin
            wb_addr_d = a_addr_q;
            wb_data_d = a_data_q;
        end else if (grant_b) begin
            wb_addr_d = b_addr_q;
            wb_data_d = b_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Buffers, arbitration state and the registered write port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_full_q  <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
            b_full_q  <= 1'b0;
            b_addr_q  <= '0;
            b_data_q  <= '0;
            rr_q      <= 1'b0;
            b_first_q <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            a_full_q  <= a_full_d;
            a_addr_q  <= a_addr_d;
            a_data_q  <= a_data_d;
            b_full_q  <= b_full_d;
            b_addr_q  <= b_addr_d;
            b_data_q  <= b_data_d;
            rr_q      <= rr_d;
            b_first_q <= b_first_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign WB_ADDR = wb_addr_q;
    assign WB_DATA = wb_data_q;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // A read is stale if its register sits in either buffer or is on the
    // write port right now. Incoming VALIDs are deliberately ignored.
    always_comb begin
        HAZ_RS = 1'b0;
        HAZ_RT = 1'b0;
        if (RSaddr != '0) begin
            HAZ_RS = (a_full_q && (a_addr_q == RSaddr)) ||
                     (b_full_q && (b_addr_q == RSaddr)) ||
                     (wb_addr_q == RSaddr);
        end
        if (RTaddr != '0) begin
            HAZ_RT = (a_full_q && (a_addr_q == RTaddr)) ||
                     (b_full_q && (b_addr_q == RTaddr)) ||
                     (wb_addr_q == RTaddr);
        end
    end

    // ------------------------------------------------------------------
    // Contention statistics
    // ------------------------------------------------------------------
`ifdef RF_WB_STATS_EN
    logic [STAT_W-1:0] stat_q, stat_d;

    // Saturating count of cycles that start with both buffers full.
    always_comb begin
        stat_d = stat_q;
        if (both_full && (stat_q != '1)) begin
            stat_d = stat_q + STAT_W'(1);
        end
    end

    // Counter register; only reset clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign STAT_CONTEND = stat_q;
`else
    assign STAT_CONTEND = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          A_VALID;
    logic [AW-1:0] A_ADDR;
    logic [DW-1:0] A_DATA;
    logic          A_READY;
    logic          B_VALID;
    logic [AW-1:0] B_ADDR;
    logic [DW-1:0] B_DATA;
    logic          B_READY;
    logic [AW-1:0] WB_ADDR;
    logic [DW-1:0] WB_DATA;
    logic [AW-1:0] RSaddr;
    logic [AW-1:0] RTaddr;
    logic          HAZ_RS;
    logic          HAZ_RT;
    logic [SW-1:0] STAT_CONTEND;

    always #5 CLK = ~CLK;

    rf_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STAT_W(SW)) dut (
        .CLK(CLK), .RST(RST),
        .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
        .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .RSaddr(RSaddr), .RTaddr(RTaddr), .HAZ_RS(HAZ_RS), .HAZ_RT(HAZ_RT),
        .STAT_CONTEND(STAT_CONTEND)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending writes as queues stamped with capture cycle.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            ts;
    } ent_t;

    ent_t          qa[$];
    ent_t          qb[$];
    bit            ptr_b;      // next different-address tie goes to B
    int            cyc;
    int            m_contend;
    logic [AW-1:0] m_wb_addr;
    logic [DW-1:0] m_wb_data;
    logic [DW-1:0] dut_rf [32]; // register file as written by the DUT's port

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_haz(input logic [AW-1:0] r);
        if (r == 0) return 1'b0;
        foreach (qa[i]) if (qa[i].addr == r) return 1'b1;
        foreach (qb[i]) if (qb[i].addr == r) return 1'b1;
        return (m_wb_addr == r);
    endfunction

    // 0 = nobody, 1 = A, 2 = B
    function automatic int m_pick();
        if (qa.size() == 0 && qb.size() == 0) return 0;
        if (qb.size() == 0) return 1;
        if (qa.size() == 0) return 2;
        if (qa[0].addr == qb[0].addr) return (qb[0].ts <= qa[0].ts) ? 2 : 1;
        return ptr_b ? 2 : 1;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        ptr_b     = 1'b0;
        m_contend = 0;
        m_wb_addr = '0;
        m_wb_data = '0;
    endtask

    task automatic drive(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        A_VALID = av; A_ADDR = aa; A_DATA = ad;
        B_VALID = bv; B_ADDR = ba; B_DATA = bd;
    endtask

    // One clock: compare at negedge, advance model, return at posedge+1.
    task automatic tick();
        int   w;
        bit   ar, br, both;
        ent_t e;
        @(negedge CLK);
        w  = m_pick();
        ar = (qa.size() == 0) || (w == 1);
        br = (qb.size() == 0) || (w == 2);
        chk("A_READY", A_READY, ar);
        chk("B_READY", B_READY, br);
        chk("WB_ADDR", WB_ADDR, m_wb_addr);
        chk("WB_DATA", WB_DATA, m_wb_data);
        chk("HAZ_RS", HAZ_RS, m_haz(RSaddr));
        chk("HAZ_RT", HAZ_RT, m_haz(RTaddr));
`ifdef RF_WB_STATS_EN
        chk("STAT", STAT_CONTEND, m_contend);
`else
        chk("STAT", STAT_CONTEND, 0);
`endif
        if (WB_ADDR != 0) dut_rf[WB_ADDR] = WB_DATA;
        both = (qa.size() != 0) && (qb.size() != 0);
        if (both && qa[0].addr != qb[0].addr) ptr_b = (w == 1);
        if (both && m_contend < 65535) m_contend++;
        m_wb_addr = '0;
        m_wb_data = '0;
        if (w == 1) begin
            m_wb_addr = qa[0].addr; m_wb_data = qa[0].data; void'(qa.pop_front());
        end else if (w == 2) begin
            m_wb_addr = qb[0].addr; m_wb_data = qb[0].data; void'(qb.pop_front());
        end
        if (A_VALID && ar && A_ADDR != 0) begin
            e.addr = A_ADDR; e.data = A_DATA; e.ts = cyc; qa.push_back(e);
        end
        if (B_VALID && br && B_ADDR != 0) begin
            e.addr = B_ADDR; e.data = B_DATA; e.ts = cyc; qb.push_back(e);
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    // Asynchronous reset applied between edges; effect must be immediate.
    task automatic pulse_reset();
        RST = 1'b1;
        #1;
        chk("RST_WB_ADDR", WB_ADDR, 0);
        chk("RST_WB_DATA", WB_DATA, 0);
        chk("RST_A_READY", A_READY, 1);
        chk("RST_B_READY", B_READY, 1);
        chk("RST_STAT", STAT_CONTEND, 0);
        model_reset();
        @(posedge CLK);
        cyc++;
        #1;
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        RSaddr = 0;
        RTaddr = 0;
        cyc = 0;
        model_reset();
        for (int i = 0; i < 32; i++) dut_rf[i] = '0;

        // Power-on reset
        @(posedge CLK);
        #1;
        chk("POR_WB_ADDR", WB_ADDR, 0);
        chk("POR_WB_DATA", WB_DATA, 0);
        chk("POR_A_READY", A_READY, 1);
        chk("POR_B_READY", B_READY, 1);
        chk("POR_STAT", STAT_CONTEND, 0);
        RST = 1'b0;

        // r0 discard
        drive(0, 0, 0, 1, 0, 32'hDEAD);
        #1;
        chk("R0_B_READY", B_READY, 1);
        chk("R0_HAZ_RS", HAZ_RS, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("R0_WB_ADDR", WB_ADDR, 0);
        tick();
        chk("R0_WB_ADDR2", WB_ADDR, 0);

        // Single requester streaming r1..r4
        for (int k = 1; k <= 4; k++) begin
            drive(1, AW'(k), DW'(k * 32'h11), 0, 0, 0);
            chk("STREAM_A_READY", A_READY, 1);
            tick();
            if (k > 1) chk("STREAM_WB", WB_ADDR, k - 1);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("STREAM_WB", WB_ADDR, 4);
        chk("STREAM_WB_DATA", WB_DATA, 32'h44);
        tick();
        chk("STREAM_IDLE", WB_ADDR, 0);

        // Hazard window on r9
        RSaddr = 9;
        RTaddr = 8;
        drive(1, 9, 32'h99, 0, 0, 0);
        tick();
        chk("HAZ_BUF", HAZ_RS, 1);
        chk("HAZ_RT_BUF", HAZ_RT, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("HAZ_WB_ADDR", WB_ADDR, 9);
        chk("HAZ_WB", HAZ_RS, 1);
        tick();
        chk("HAZ_CLEAR", HAZ_RS, 0);
        chk("HAZ_RT_CLEAR", HAZ_RT, 0);
        RSaddr = 0;
        RTaddr = 0;

        // Contention round-robin, twice
        for (int rep = 0; rep < 2; rep++) begin
            drive(1, 5, 32'hAAAA, 1, 6, 32'hBBBB);
            tick();
            drive(0, 0, 0, 0, 0, 0);
            tick();
            chk("RR_FIRST", WB_ADDR, (rep == 0) ? 5 : 6);
            tick();
            chk("RR_SECOND", WB_ADDR, (rep == 0) ? 6 : 5);
            chk("RR_SECOND_DATA", WB_DATA, (rep == 0) ? 32'hBBBB : 32'hAAAA);
        end
`ifdef RF_WB_STATS_EN
        chk("RR_STAT", STAT_CONTEND, 2);
`else
        chk("RR_STAT", STAT_CONTEND, 0);
`endif

        // Same-address conflict on r7
        drive(1, 7, 32'h1, 1, 7, 32'h2);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("SAME_1ST_ADDR", WB_ADDR, 7);
        chk("SAME_1ST_DATA", WB_DATA, 32'h2);
        tick();
        chk("SAME_2ND_ADDR", WB_ADDR, 7);
        chk("SAME_2ND_DATA", WB_DATA, 32'h1);
        tick();
        chk("SAME_FINAL_R7", dut_rf[7], 32'h1);

        // Reset mid-stream: r3 captured, reset before its grant
        drive(1, 3, 32'h33, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        dut_rf[3] = '0;
        pulse_reset();
        for (int k = 0; k < 3; k++) tick();
        chk("RST_NO_R3", dut_rf[3], 0);

        // Randomized traffic with a small address range to force conflicts
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom);
            RSaddr = AW'($urandom_range(0, 7));
            RTaddr = AW'($urandom_range(0, 7));
            tick();
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
